// File: rtl/fe_frombytes.sv
// ---------------------------------------------------------------------------
// fe_frombytes
//
// Sequential decoder from the 32-byte little-endian encoding of a field
// element (mod 2^255-19) to the 10-limb signed radix-2^25.5 representation
// used by the fe_* arithmetic blocks. Bit 255 of the encoding is discarded,
// the limbs are loaded with their byte-aligned shifts, and then the ref10
// carry chain runs one carry per cycle so every limb leaves in reduced
// signed range.
//
// Ports:
//   clk    in   1    system clock, rising edge
//   rst    in   1    asynchronous active-low reset
//   in     in   256  encoded element, byte k at in[k*8 +: 8]
//   valid  in   1    request strobe, only looked at while idle
//   out    out  320  limb i (32-bit two's complement) at out[i*32 +: 32]
//   busy   out  1    high from the capture edge through the done cycle
//   done   out  1    one-cycle pulse, out is valid from this cycle on
//
// Timing: capture edge E, carries on E+1..E+10, out/done registered on
// E+11. A new request can be captured on E+12, giving 1 result / 12 cycles.
// ---------------------------------------------------------------------------
module fe_frombytes (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] in,
    input  logic         valid,
    output logic [319:0] out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_C9,
        S_C1,
        S_C3,
        S_C5,
        S_C7,
        S_C0,
        S_C2,
        S_C4,
        S_C6,
        S_C8,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [319:0]       out_q,  out_d;

    logic signed [63:0] h_q [10];
    logic signed [63:0] h_d [10];
    logic signed [63:0] load_val [10];

    // Carry-step datapath signals
    logic               carry_en;
    logic [3:0]         carry_idx;
    logic [3:0]         carry_dst;
    logic signed [63:0] carry_src;
    logic signed [63:0] carry_c;
    logic signed [63:0] carry_sub;
    logic signed [63:0] carry_add;

    // -----------------------------------------------------------------------
    // Limb load from the byte encoding. Zero padding on the left keeps every
    // loaded value non-negative; bit 255 is dropped by only taking 23 bits
    // of the top three bytes for h9.
    // -----------------------------------------------------------------------
    always_comb begin
        load_val[0] = {32'd0, in[  0 +: 32]};
        load_val[1] = {34'd0, in[ 32 +: 24], 6'd0};
        load_val[2] = {35'd0, in[ 56 +: 24], 5'd0};
        load_val[3] = {37'd0, in[ 80 +: 24], 3'd0};
        load_val[4] = {38'd0, in[104 +: 24], 2'd0};
        load_val[5] = {32'd0, in[128 +: 32]};
        load_val[6] = {33'd0, in[160 +: 24], 7'd0};
        load_val[7] = {35'd0, in[184 +: 24], 5'd0};
        load_val[8] = {36'd0, in[208 +: 24], 4'd0};
        load_val[9] = {39'd0, in[232 +: 23], 2'd0};
    end

    // -----------------------------------------------------------------------
    // Which limb the current state carries out of, and where the carry goes.
    // -----------------------------------------------------------------------
    always_comb begin
        carry_en  = 1'b1;
        carry_idx = 4'd0;
        case (state_q)
            S_C9:    carry_idx = 4'd9;
            S_C1:    carry_idx = 4'd1;
            S_C3:    carry_idx = 4'd3;
            S_C5:    carry_idx = 4'd5;
            S_C7:    carry_idx = 4'd7;
            S_C0:    carry_idx = 4'd0;
            S_C2:    carry_idx = 4'd2;
            S_C4:    carry_idx = 4'd4;
            S_C6:    carry_idx = 4'd6;
            S_C8:    carry_idx = 4'd8;
            default: carry_en  = 1'b0;
        endcase
        // h9 wraps around to h0 (the x19 fold happens below)
        carry_dst = (carry_idx == 4'd9) ? 4'd0 : carry_idx + 4'd1;
    end

    // Odd limbs hold 25 bits, even limbs 26 bits. Adding half the radix
    // before the arithmetic shift gives a round-to-nearest carry, which
    // leaves the limb centred on zero.
    always_comb begin
        carry_src = h_q[carry_idx];
        if (carry_idx[0]) begin
            carry_c   = (carry_src + 64'sd16777216) >>> 25;
            carry_sub = carry_c <<< 25;
        end else begin
            carry_c   = (carry_src + 64'sd33554432) >>> 26;
            carry_sub = carry_c <<< 26;
        end
        // 2^255 == 19 mod p, so the carry out of h9 re-enters h0 times 19
        if (carry_idx == 4'd9)
            carry_add = (carry_c <<< 4) + (carry_c <<< 1) + carry_c;
        else
            carry_add = carry_c;
    end

    // -----------------------------------------------------------------------
    // Limb next-state: load on capture, one carry step per carry state,
    // hold otherwise.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_limb
            always_comb begin
                h_d[gi] = h_q[gi];
                if (state_q == S_IDLE) begin
                    if (valid)
                        h_d[gi] = load_val[gi];
                end else if (carry_en) begin
                    if (carry_idx == 4'(gi))
                        h_d[gi] = h_q[gi] - carry_sub;
                    else if (carry_dst == 4'(gi))
                        h_d[gi] = h_q[gi] + carry_add;
                end
            end

            // Limbs carry no meaning outside a conversion, so no reset.
            always_ff @(posedge clk) begin
                h_q[gi] <= h_d[gi];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM next-state and output-register next values.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                // busy stays up through the done cycle (which is an IDLE
                // cycle) and drops afterwards unless a new request arrives.
                busy_d = valid;
                if (valid)
                    state_d = S_C9;
            end
            S_C9:   state_d = S_C1;
            S_C1:   state_d = S_C3;
            S_C3:   state_d = S_C5;
            S_C5:   state_d = S_C7;
            S_C7:   state_d = S_C0;
            S_C0:   state_d = S_C2;
            S_C2:   state_d = S_C4;
            S_C4:   state_d = S_C6;
            S_C6:   state_d = S_C8;
            S_C8:   state_d = S_OUT;
            S_OUT: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                for (int i = 0; i < 10; i++)
                    out_d[i*32 +: 32] = h_q[i][31:0];
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fe_frombytes.sv
// ---------------------------------------------------------------------------
// tb_fe_frombytes
//
// Directed bench for fe_frombytes. Inputs are driven and outputs sampled on
// the falling clock edge. Expected limb vectors are hand-computed.
// ---------------------------------------------------------------------------
module tb_fe_frombytes;

    logic         clk;
    logic         rst;
    logic [255:0] in_data;
    logic         valid;
    logic [319:0] out_data;
    logic         busy;
    logic         done;

    int checks;
    int passed;

    fe_frombytes dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in_data),
        .valid (valid),
        .out   (out_data),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [319:0] limbs(
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
        input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
        input logic [31:0] a6, input logic [31:0] a7, input logic [31:0] a8,
        input logic [31:0] a9);
        return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // One complete conversion with latency, busy-width and result checks.
    task automatic run_conv(input string name, input logic [255:0] vec,
                            input logic [319:0] exp_out);
        int lat;
        int busy_cnt;
        @(negedge clk);
        in_data = vec;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        in_data = ~vec;   // must not be resampled
        checks++;
        if (busy !== 1'b1)
            $display("FAIL %s busy_after_capture got=%b want=1", name, busy);
        else
            passed++;
        lat      = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 && lat == 0)
                lat = k;
            if (busy === 1'b1)
                busy_cnt++;
            else
                break;
        end
        checks++;
        if (done !== 1'b0)
            $display("FAIL %s done_width got=%b want=0 after pulse", name, done);
        else
            passed++;
        checks++;
        if (lat != 11)
            $display("FAIL %s done_latency got=%0d want=11", name, lat);
        else
            passed++;
        checks++;
        if (busy_cnt != 12)
            $display("FAIL %s busy_cycles got=%0d want=12", name, busy_cnt);
        else
            passed++;
        checks++;
        if (out_data !== exp_out)
            $display("FAIL %s out got=%h want=%h", name, out_data, exp_out);
        else
            passed++;
        $display("conv %-10s lat=%0d busy=%0d out=%h", name, lat, busy_cnt, out_data);
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        valid   = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_data !== 320'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_state got out=%h busy=%b done=%b want 0/0/0",
                     out_data, busy, done);
        else
            passed++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset got busy=%b done=%b want 0/0", busy, done);
        else
            passed++;
        $display("reset busy=%b done=%b out=%h", busy, done, out_data);
    endtask

    task automatic test_zero();
        run_conv("zero", 256'd0, 320'd0);
    endtask

    task automatic test_one();
        run_conv("one", 256'h01, limbs(32'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_limb_loads();
        logic [255:0] v;
        v = '0;
        v[  0 +: 8] = 8'h01;
        v[ 32 +: 8] = 8'h01;
        v[ 56 +: 8] = 8'h01;
        v[ 80 +: 8] = 8'h01;
        v[104 +: 8] = 8'h01;
        v[128 +: 8] = 8'h01;
        v[160 +: 8] = 8'h01;
        v[184 +: 8] = 8'h01;
        v[208 +: 8] = 8'h01;
        v[232 +: 8] = 8'h01;
        run_conv("loads", v, limbs(32'd1, 32'd64, 32'd32, 32'd8, 32'd4,
                                   32'd1, 32'd128, 32'd32, 32'd16, 32'd4));
    endtask

    task automatic test_carry_c0();
        run_conv("carry_c0", 256'hFFFFFFFF,
                 limbs(32'hFFFFFFFF, 32'd64, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_carry_c2();
        logic [255:0] v;
        v = '0;
        v[56 +: 24] = 24'hFFFFFF;
        run_conv("carry_c2", v,
                 limbs(0, 0, 32'hFFFFFFE0, 32'd8, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_fold_c9();
        run_conv("fold_c9", {8'h7F, 248'd0},
                 limbs(32'd19, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFC0000));
    endtask

    task automatic test_bit255_mask();
        run_conv("bit255", {8'h80, 248'd0}, 320'd0);
    endtask

    task automatic test_back_to_back();
        logic [319:0] exp_a;
        logic [319:0] exp_b;
        int n_done;
        int busy_low;
        exp_a = limbs(32'hFFFFFFFF, 32'd64, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_b = limbs(32'd19, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFC0000);
        @(negedge clk);
        in_data = 256'hFFFFFFFF;
        valid   = 1'b1;
        @(negedge clk);
        in_data  = {8'h7F, 248'd0};
        n_done   = 0;
        busy_low = 0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (done === 1'b1)
                n_done++;
            if (busy !== 1'b1)
                busy_low++;
            if (k == 11) begin
                checks++;
                if (done !== 1'b1 || out_data !== exp_a)
                    $display("FAIL b2b_first got done=%b out=%h want done=1 out=%h",
                             done, out_data, exp_a);
                else
                    passed++;
            end
            if (k == 12) begin
                valid   = 1'b0;
                in_data = 256'h1234;
            end
            if (k == 16) valid = 1'b1;   // ignored: conversion in progress
            if (k == 17) valid = 1'b0;
            if (k == 23) begin
                checks++;
                if (done !== 1'b1 || out_data !== exp_b)
                    $display("FAIL b2b_second got done=%b out=%h want done=1 out=%h",
                             done, out_data, exp_b);
                else
                    passed++;
            end
        end
        checks++;
        if (n_done != 2)
            $display("FAIL b2b_done_count got=%0d want=2", n_done);
        else
            passed++;
        checks++;
        if (busy_low != 0)
            $display("FAIL b2b_busy_gap got=%0d low cycles want=0", busy_low);
        else
            passed++;
        n_done = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL b2b_busy_drop got=%b want=0", busy);
        else
            passed++;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1)
                n_done++;
        end
        checks++;
        if (n_done != 0)
            $display("FAIL b2b_spurious_done got=%0d want=0", n_done);
        else
            passed++;
        $display("b2b first/second checked, out=%h", out_data);
    endtask

    task automatic test_reset_abort();
        int n_done;
        @(negedge clk);
        in_data = 256'hFFFFFFFF;
        valid   = 1'b1;
        @(negedge clk);   // in C9
        valid = 1'b0;
        @(negedge clk);   // in C1
        @(negedge clk);   // in C3
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_data !== 320'd0)
            $display("FAIL abort_reset got busy=%b done=%b out=%h want 0/0/0",
                     busy, done, out_data);
        else
            passed++;
        @(negedge clk);
        rst    = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1)
                n_done++;
        end
        checks++;
        if (n_done != 0)
            $display("FAIL abort_no_done got=%0d active cycles want=0", n_done);
        else
            passed++;
        $display("abort busy=%b done=%b out=%h", busy, done, out_data);
        run_conv("after_rst", 256'h01, limbs(32'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst     = 1'b0;
        valid   = 1'b0;
        in_data = '0;
        test_reset();
        test_zero();
        test_one();
        test_limb_loads();
        test_carry_c0();
        test_carry_c2();
        test_fold_c9();
        test_bit255_mask();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
